ewb_fifo: RTL

EWB_FIFO -- requirements
Module: ewb_fifo

---
 rtl/ewb_if.sv | 33 +++
 rtl/ewb_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ewb_if.sv
// Upstream (L2) and pmem signal bundle for the eviction write buffer.
// The slave modport is the buffer itself. The master modport is the surrounding cache/memory side.
interface ewb_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              read_i;
  logic              write_i;
  logic [ADDR_W-1:0] addr_i;
  logic [LINE_W-1:0] wdata_i;
  logic [LINE_W-1:0] rdata_o;
  logic              resp_o;
  logic              read_o;
  logic              write_o;
  logic [ADDR_W-1:0] addr_o;
  logic [LINE_W-1:0] wdata_o;
  logic [LINE_W-1:0] rdata_i;
  logic              resp_i;
  logic [CNT_W-1:0]  count_o;

  modport slave (
    input  read_i, write_i, addr_i, wdata_i, rdata_i, resp_i,
    output rdata_o, resp_o, read_o, write_o, addr_o, wdata_o, count_o
  );

  modport master (
    output read_i, write_i, addr_i, wdata_i, rdata_i, resp_i,
    input  rdata_o, resp_o, read_o, write_o, addr_o, wdata_o, count_o
  );
endinterface

// File: rtl/ewb_fifo.sv
// Eviction write buffer: victim lines are queued here and drained to pmem; reads are served from the buffer on a hit.
// Optional macro EWB_COALESCE_EN merges a write into an existing queued entry with the same address.
module ewb_fifo #(
  parameter int LINE_W     = 256,
  parameter int ADDR_W     = 32,
  parameter int DEPTH      = 4,
  parameter int DRAIN_IDLE = 8
) (
  input logic  clk,
  input logic  rst,
  ewb_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDL_W = $clog2(DRAIN_IDLE + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic [IDL_W-1:0]  idle_cnt, idle_nxt;

  logic              rd_hit;
  logic [PTR_W-1:0]  rd_idx, scan_idx;
  logic              full, has_ent;
  logic              wr_req, wr_merge, wr_alloc, wr_ack, wr_stall;
  logic              drain_trig, push, pop;
  logic              mem_read, mem_write, up_resp;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata, up_rdata;
`ifdef EWB_COALESCE_EN
  logic              wr_hit;
  logic [PTR_W-1:0]  wr_idx;
`endif

  function automatic logic [IDL_W-1:0] sat_inc(input logic [IDL_W-1:0] v);
    return (v >= IDL_W'(DRAIN_IDLE)) ? IDL_W'(DRAIN_IDLE) : v + 1'b1;
  endfunction

  // Scan oldest to newest so the last match is the newest copy of the line.
  always_comb begin
    rd_hit   = 1'b0;
    rd_idx   = '0;
    scan_idx = '0;
`ifdef EWB_COALESCE_EN
    wr_hit   = 1'b0;
    wr_idx   = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PTR_W'(i);
      if (valid_q[scan_idx] && (addr_q[scan_idx] == bus.addr_i)) begin
        rd_hit = 1'b1;
        rd_idx = scan_idx;
`ifdef EWB_COALESCE_EN
        if (!((state == S_WRITE) && (scan_idx == head))) begin
          wr_hit = 1'b1;
          wr_idx = scan_idx;
        end
`endif
      end
    end
  end

  assign full    = (count == CNT_W'(DEPTH));
  assign has_ent = (count != '0);
  assign wr_req  = bus.write_i && !bus.read_i;

`ifdef EWB_COALESCE_EN
  assign wr_merge = wr_req && wr_hit && (state != S_READ);
`else
  assign wr_merge = 1'b0;
`endif
  // No push-on-pop bypass: a full buffer refuses allocation even on the popping cycle.
  assign wr_alloc = wr_req && !wr_merge && !full && (state != S_READ);
  assign wr_ack   = wr_merge || wr_alloc;
  assign wr_stall = wr_req && !wr_ack;

  assign idle_nxt   = (!has_ent || bus.read_i || bus.write_i) ? '0 : sat_inc(idle_cnt);
  assign drain_trig = has_ent && (full || wr_stall || (idle_nxt == IDL_W'(DRAIN_IDLE)));
  assign push       = wr_alloc && !rst;
  assign pop        = (state == S_WRITE) && bus.resp_i;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    up_resp   = 1'b0;
    mem_addr  = addr_q[head];
    mem_wdata = data_q[head];
    up_rdata  = bus.rdata_i;
    unique case (state)
      S_IDLE: begin
        if (bus.read_i) begin
          if (rd_hit) begin
            up_resp  = 1'b1;
            up_rdata = data_q[rd_idx];
          end else begin
            mem_read = 1'b1;
            mem_addr = bus.addr_i;
            up_resp  = bus.resp_i;
            if (!bus.resp_i) state_nxt = S_READ;
          end
        end else begin
          up_resp = wr_ack;
          if (drain_trig) state_nxt = S_WRITE;
        end
      end
      S_READ: begin
        mem_read = 1'b1;
        mem_addr = bus.addr_i;
        up_resp  = bus.resp_i;
        if (bus.resp_i) state_nxt = drain_trig ? S_WRITE : S_IDLE;
      end
      S_WRITE: begin
        mem_write = 1'b1;
        if (bus.read_i) begin
          if (rd_hit) begin
            up_resp  = 1'b1;
            up_rdata = data_q[rd_idx];
          end
        end else begin
          up_resp = wr_ack;
        end
        if (bus.resp_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid_q  <= '0;
      idle_cnt <= '0;
    end else begin
      if (pop) begin
        valid_q[head] <= 1'b0;
        head          <= head + 1'b1;
      end
      if (push) begin
        valid_q[tail] <= 1'b1;
        tail          <= tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      idle_cnt <= idle_nxt;
    end
  end

  // Line storage carries no reset; valid_q alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= bus.addr_i;
      data_q[tail] <= bus.wdata_i;
    end
`ifdef EWB_COALESCE_EN
    if (wr_merge && !rst) data_q[wr_idx] <= bus.wdata_i;
`endif
  end

  assign bus.read_o  = mem_read  && !rst;
  assign bus.write_o = mem_write && !rst;
  assign bus.resp_o  = up_resp   && !rst;
  assign bus.addr_o  = mem_addr;
  assign bus.wdata_o = mem_wdata;
  assign bus.rdata_o = up_rdata;
  assign bus.count_o = count;

endmodule
